// File: rtl/loss_input_stager.sv
`default_nettype none
// loss_input_stager: stages N serial FC scores plus a one-hot label for the loss stage,
// launches it and hands the loss back on valid/ready. Optional watchdog: LOSS_WATCHDOG_EN.
module loss_input_stager #(
   parameter int FC_OUTPUT_SIZE = 10,
   parameter int LABEL_W        = 4,
   parameter int LOSS_MIN_LAT   = 11,
   parameter int WDOG_CYCLES    = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_data,
   input  logic [LABEL_W-1:0]        in_label,
   output logic [31:0]               predicted_probs [FC_OUTPUT_SIZE],
   output logic [FC_OUTPUT_SIZE-1:0] ground_truth,
   output logic                      loss_start,
   input  logic [31:0]               loss_in,
   input  logic                      loss_done,
   output logic [31:0]               loss_out,
   output logic                      loss_valid,
   input  logic                      loss_ready,
   output logic                      label_err,
   output logic                      timeout,
   output logic                      busy
);
   localparam int               CNT_W   = (FC_OUTPUT_SIZE > 1) ? $clog2(FC_OUTPUT_SIZE) : 1;
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(FC_OUTPUT_SIZE - 1);
   localparam logic [31:0]      N_U     = 32'(FC_OUTPUT_SIZE);
   localparam logic [15:0]      MIN_LAT = 16'(LOSS_MIN_LAT);
`ifdef LOSS_WATCHDOG_EN
   localparam logic [15:0]      WDOG_LIM = 16'(WDOG_CYCLES);
`endif

   if ((1 << LABEL_W) < FC_OUTPUT_SIZE || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_param_check
      $error("loss_input_stager: LABEL_W too narrow for FC_OUTPUT_SIZE or WDOG_CYCLES out of range");
   end

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_OUTPUT = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [15:0]      wcnt;
   logic             label_err_q;

   assign in_ready  = (state == S_FILL);
   assign busy      = (state != S_FILL) || (count != '0);
   assign label_err = label_err_q;

`ifndef LOSS_WATCHDOG_EN
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_FILL;
         count        <= '0;
         wcnt         <= '0;
         ground_truth <= '0;
         label_err_q  <= 1'b0;
         loss_start   <= 1'b0;
         loss_out     <= '0;
         loss_valid   <= 1'b0;
         for (int i = 0; i < FC_OUTPUT_SIZE; i++) predicted_probs[i] <= '0;
`ifdef LOSS_WATCHDOG_EN
         timeout      <= 1'b0;
`endif
      end else begin
         loss_start <= 1'b0;
         case (state)
            S_FILL: begin
               if (in_valid) begin
                  predicted_probs[count] <= in_data;
                  if (count == '0) begin
                     // Out-of-range class: no bit set, flagged with the result.
                     if (32'(in_label) < N_U) begin
                        ground_truth <= FC_OUTPUT_SIZE'(1) << in_label;
                        label_err_q  <= 1'b0;
                     end else begin
                        ground_truth <= '0;
                        label_err_q  <= 1'b1;
                     end
                  end
                  if (count == LAST) begin
                     count      <= '0;
                     loss_start <= 1'b1;
                     state      <= S_LAUNCH;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            S_LAUNCH: begin
               wcnt  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (wcnt != 16'hFFFF) wcnt <= wcnt + 16'd1;
               // loss_done is a level that may still be high from the previous sample.
               if (loss_done && (wcnt >= MIN_LAT)) begin
                  loss_out   <= loss_in;
                  loss_valid <= 1'b1;
                  state      <= S_OUTPUT;
               end
`ifdef LOSS_WATCHDOG_EN
               else if (wcnt >= WDOG_LIM) begin
                  loss_out   <= 32'hFFFF_FFFF;
                  timeout    <= 1'b1;
                  loss_valid <= 1'b1;
                  state      <= S_OUTPUT;
               end
`endif
            end
            S_OUTPUT: begin
               if (loss_ready) begin
                  loss_valid  <= 1'b0;
                  label_err_q <= 1'b0;
`ifdef LOSS_WATCHDOG_EN
                  timeout     <= 1'b0;
`endif
                  state       <= S_FILL;
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_loss_input_stager.sv
`default_nettype none
// Bench for loss_input_stager: transaction-level model with per-cycle compare,
// directed cases with literal expectations, then randomized samples.
module tb_loss_input_stager;
   localparam int N       = 10;
   localparam int LW      = 4;
   localparam int MIN_LAT = 11;
   localparam int WDOG    = 32;
`ifdef LOSS_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic          clk = 1'b0, rst = 1'b1;
   logic          in_valid = 1'b0, loss_done = 1'b0, loss_ready = 1'b0;
   logic [31:0]   in_data = '0, loss_in = '0;
   logic [LW-1:0] in_label = '0;
   logic          in_ready, loss_start, loss_valid, label_err, timeout, busy;
   logic [31:0]   predicted_probs [N];
   logic [N-1:0]  ground_truth;
   logic [31:0]   loss_out;

   loss_input_stager #(.FC_OUTPUT_SIZE(N), .LABEL_W(LW), .LOSS_MIN_LAT(MIN_LAT), .WDOG_CYCLES(WDOG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_label(in_label), .predicted_probs(predicted_probs), .ground_truth(ground_truth),
      .loss_start(loss_start), .loss_in(loss_in), .loss_done(loss_done), .loss_out(loss_out),
      .loss_valid(loss_valid), .loss_ready(loss_ready), .label_err(label_err),
      .timeout(timeout), .busy(busy));

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Latency from the accept cycle of the last score to the first loss_valid cycle.
   function automatic int exp_lat(input int d, input bit stuck);
      int first_ok;
      if (!stuck && d == 0) return 3 + WDOG;
      first_ok = stuck ? 0 : d - 1;
      return 3 + ((first_ok > MIN_LAT) ? first_ok : MIN_LAT);
   endfunction

   // Model state
   int           cyc = 0, elems = 0, acc_cyc = 0, lat_exp = 0, starts = 0;
   bit           pend = 1'b0, acc, exp_valid, to_exp, prev_lv = 1'b0;
   logic [31:0]  cur_data [N];
   logic [31:0]  pend_data [N];
   int           cur_label = 0, pend_label = 0;
   logic [31:0]  pend_val = '0, nx_val = '0, out_exp;
   int           pend_d = 1, nx_d = 1;
   bit           pend_stuck = 1'b0, nx_stuck = 1'b0;
   logic [N-1:0] gexp;
   int           last_lat = 0;
   logic [31:0]  last_out = '0;
   logic [N-1:0] last_gt = '0;
   logic         last_err = 1'b0, last_to = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         check("rst_loss_valid", loss_valid, 0);
         check("rst_loss_start", loss_start, 0);
         check("rst_in_ready", in_ready, 1);
         check("rst_busy", busy, 0);
         check("rst_loss_out", loss_out, 0);
         check("rst_gt", 32'(ground_truth), 0);
         check("rst_label_err", label_err, 0);
         check("rst_timeout", timeout, 0);
         for (int k = 0; k < N; k++) check("rst_probs", predicted_probs[k], 0);
         elems = 0; pend = 1'b0; prev_lv = 1'b0;
      end else begin
         exp_valid = pend && (cyc >= acc_cyc + lat_exp);
         check("in_ready", in_ready, {31'b0, !pend});
         check("busy", busy, {31'b0, pend || (elems != 0)});
         check("loss_start", loss_start, {31'b0, pend && (cyc == acc_cyc + 1)});
         check("loss_valid", loss_valid, {31'b0, exp_valid});
         if (loss_start) starts++;
         if (pend && cyc > acc_cyc) begin
            gexp = '0;
            if (pend_label < N) gexp[pend_label] = 1'b1;
            check("gt", 32'(ground_truth), 32'(gexp));
            for (int k = 0; k < N; k++) check("probs", predicted_probs[k], pend_data[k]);
         end
         if (exp_valid) begin
            to_exp  = WD_ON && !pend_stuck && (pend_d == 0);
            out_exp = to_exp ? 32'hFFFF_FFFF : pend_val;
            check("loss_out", loss_out, out_exp);
            check("label_err", label_err, {31'b0, pend_label >= N});
            check("timeout", timeout, {31'b0, to_exp});
         end
         if (loss_valid && !prev_lv && pend) begin
            last_lat = cyc - acc_cyc; last_out = loss_out; last_gt = ground_truth;
            last_err = label_err;     last_to = timeout;
         end
         prev_lv = loss_valid;
         acc = in_valid && !pend;
         if (exp_valid && loss_ready) pend = 1'b0;
         if (acc) begin
            cur_data[elems] = in_data;
            if (elems == 0) cur_label = int'(in_label);
            elems++;
            if (elems == N) begin
               for (int k = 0; k < N; k++) pend_data[k] = cur_data[k];
               pend_label = cur_label; pend_val = nx_val; pend_d = nx_d; pend_stuck = nx_stuck;
               lat_exp = exp_lat(nx_d, nx_stuck);
               acc_cyc = cyc; pend = 1'b1; elems = 0;
            end
         end
      end
   end

   // Loss-stage stub: done rises pend_d cycles after the launch cycle (0 = never);
   // in stuck mode the previous high level is simply left in place.
   int stub_c = 0;
   bit stub_run = 1'b0;
   initial forever begin
      @(posedge clk); #1;
      if (loss_start) begin
         loss_in = pend_val; stub_c = 0;
         stub_run = !pend_stuck && (pend_d > 0);
         if (!pend_stuck) loss_done = 1'b0;
      end else begin
         stub_c++;
      end
      if (stub_run && stub_c >= pend_d) loss_done = 1'b1;
   end

   int ready_mode = 0;   // 0 random, 1 low, 2 high
   initial forever begin
      @(posedge clk); #1;
      loss_ready = (ready_mode == 2) || (ready_mode == 0 && $urandom_range(0, 2) != 0);
   end

   task automatic send(input int nelem, input logic [31:0] base, input bit rnd, input int lab, input int gap);
      for (int k = 0; k < nelem; k++) begin
         int guard = 0;
         while (gap > 0 && $urandom_range(0, gap) != 0) begin
            in_valid = 1'b0; @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = rnd ? $urandom : base + 32'(k);
         in_label = (k == 0) ? LW'(lab) : LW'($urandom);
         @(negedge clk);
         while (!in_ready && guard < 300) begin @(negedge clk); guard++; end
         if (guard >= 300) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, need 1", guard);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = $urandom;
   endtask

   task automatic wait_idle(input int limit);
      int g = 0;
      while (pend && g < limit) begin @(posedge clk); #1; g++; end
      total++;
      if (pend) begin
         bad++;
         $display("FAIL wait_idle: result still pending=%0d after %0d cycles, need 0", pend, limit);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, got %0d cycles", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      int s0, g;
      repeat (2) @(posedge clk);
      #1;
      check("init_in_ready", in_ready, 1);
      check("init_loss_valid", loss_valid, 0);
      rst = 1'b0;

      // Case 1: ramp scores, label 3, done first visible at wcnt 11
      ready_mode = 2; nx_val = 32'h0000_1234; nx_d = 12; nx_stuck = 1'b0; s0 = starts;
      send(N, 32'h3F00_0000, 1'b0, 3, 0);
      wait_idle(200);
      check("t1_gt", 32'(last_gt), 32'b0000001000);
      check("t1_out", last_out, 32'h0000_1234);
      check("t1_err", last_err, 0);
      check("t1_starts", starts - s0, 1);
      check("t1_lat", last_lat, 14);

      // Case 2: done still high from case 1; must wait the full minimum latency
      nx_val = 32'hBEEF_0002; nx_d = 1; nx_stuck = 1'b1;
      send(N, '0, 1'b1, 7, 0);
      wait_idle(200);
      check("t2_out", last_out, 32'hBEEF_0002);
      check("t2_lat", last_lat, 14);

      // Case 3: out-of-range label
      nx_val = 32'h0000_0033; nx_d = 5; nx_stuck = 1'b0;
      send(N, '0, 1'b1, 12, 1);
      wait_idle(200);
      check("t3_err", last_err, 1);
      check("t3_gt", 32'(last_gt), 0);
      check("t3_err_cleared", label_err, 0);

      // Case 4: consumer stalls 20 cycles
      ready_mode = 1; nx_val = 32'hCAFE_0004; nx_d = 20;
      send(N, '0, 1'b1, 9, 0);
      g = 0;
      while (!loss_valid && g < 300) begin @(posedge clk); #1; g++; end
      check("t4_valid_seen", loss_valid, 1);
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("t4_hold_valid", loss_valid, 1);
         check("t4_hold_out", loss_out, 32'hCAFE_0004);
         check("t4_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      ready_mode = 2;
      wait_idle(50);
      check("t4_lat", last_lat, 22);

      // Case 5: reset mid-fill, then mid-wait
      nx_val = 32'h5555_0005; nx_d = 3;
      send(5, '0, 1'b1, 2, 0);
      rst = 1'b1; #2;
      check("t5a_in_ready", in_ready, 1);
      check("t5a_busy", busy, 0);
      @(posedge clk); #1; rst = 1'b0;
      nx_d = 25;
      send(N, '0, 1'b1, 4, 0);
      repeat (6) @(posedge clk);
      #1;
      check("t5b_busy_before", busy, 1);
      rst = 1'b1; #2;
      check("t5b_busy", busy, 0);
      check("t5b_in_ready", in_ready, 1);
      @(posedge clk); #1; rst = 1'b0;
      nx_val = 32'h6666_0006; nx_d = 2;
      send(N, 32'h1000_0000, 1'b0, 0, 0);
      wait_idle(200);
      check("t5_out", last_out, 32'h6666_0006);
      check("t5_gt", 32'(last_gt), 32'b0000000001);

`ifdef LOSS_WATCHDOG_EN
      // Case 6: loss stage never answers
      nx_val = 32'h7777_0007; nx_d = 0; nx_stuck = 1'b0;
      send(N, '0, 1'b1, 1, 0);
      wait_idle(300);
      check("t6_out", last_out, 32'hFFFF_FFFF);
      check("t6_to", last_to, 1);
      check("t6_lat", last_lat, 3 + WDOG);
`endif

      // Randomized samples, overlapping sends with pending results
      ready_mode = 0;
      for (int s = 0; s < 30; s++) begin
         nx_val   = $urandom;
         nx_d     = (WD_ON && $urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
         nx_stuck = loss_done && ($urandom_range(0, 2) == 0);
         send(N, '0, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end
      wait_idle(300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
